// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requester bank (master) and rr_arbiter8 (slave).
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  modport master (output req, done, input gnt, gnt_idx, gnt_vld, tmo);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, tmo);
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot and indexed grant.
// Optional forced release after HOLD_MAX cycles is compiled in by RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_arbiter8_if.slave     bus,
  output logic [0:0]       dbg_state,
  output logic [2:0]       dbg_ptr,
  output logic [7:0]       dbg_cnt
);

  // Handshake: a grant starts one cycle after a nonzero req is seen in IDLE and
  // lasts until done, the owner dropping its req bit, or (optionally) timeout;
  // every grant is followed by exactly one IDLE cycle.

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Elaboration fails on an out-of-range hold limit by instantiating a missing module.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    rr_arbiter8_illegal_hold_max u_illegal ();
  end

  logic [0:0] state;
  logic [2:0] ptr;
  logic [7:0] cnt;
  logic [7:0] gnt_q;
  logic [2:0] gnt_idx_q;
  logic       gnt_vld_q;
  logic       tmo_q;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       hold_hit;
  logic       normal_rel;
  logic       release_now;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  assign hold_hit = (cnt == 8'(HOLD_MAX));
`else
  assign hold_hit = 1'b0;
`endif

  // Dropping req is a voluntary release, so it suppresses tmo just like done.
  assign normal_rel  = bus.done || !bus.req[gnt_idx_q];
  assign release_now = normal_rel || hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= 8'd0;
      gnt_q     <= 8'h00;
      gnt_idx_q <= 3'd0;
      gnt_vld_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_q <= 1'b0;
          if (win_found) begin
            state     <= GRANT;
            gnt_q     <= 8'h01 << win_idx;
            gnt_idx_q <= win_idx;
            gnt_vld_q <= 1'b1;
            cnt       <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            ptr       <= gnt_idx_q + 3'd1;
            gnt_q     <= 8'h00;
            gnt_idx_q <= 3'd0;
            gnt_vld_q <= 1'b0;
            cnt       <= 8'd0;
            tmo_q     <= hold_hit && !normal_rel;
          end else begin
            tmo_q <= 1'b0;
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_q     <= 8'h00;
          gnt_idx_q <= 3'd0;
          gnt_vld_q <= 1'b0;
          tmo_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.tmo     = tmo_q;
  assign dbg_state   = state;
  assign dbg_ptr     = ptr;
  assign dbg_cnt     = cnt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8; covers the timeout build when
// RR_ARB_TIMEOUT_EN is defined, otherwise the unbounded-hold build.
module tb_rr_arbiter8;
  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;
  logic [2:0] dbg_ptr;
  logic [7:0] dbg_cnt;
  int         checks;
  int         failures;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr),
    .dbg_cnt   (dbg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.gnt_idx !== 3'd0 || bus.tmo !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%h idx=%0d vld=%b tmo=%b, need 00/0/0/0",
               bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo);
    end
    checks++;
    if (dbg_state !== 1'b0 || dbg_ptr !== 3'd0 || dbg_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: state=%b ptr=%0d cnt=%0d, need 0/0/0", dbg_state, dbg_ptr, dbg_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.req = 8'h05;
    tick();
    checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0 || bus.gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL basic_first: gnt=%h idx=%0d vld=%b, need 01/0/1", bus.gnt, bus.gnt_idx, bus.gnt_vld);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.tmo !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_gap: gnt=%h vld=%b tmo=%b, need 00/0/0", bus.gnt, bus.gnt_vld, bus.tmo);
    end
    tick();
    checks++;
    if (bus.gnt !== 8'h04 || bus.gnt_idx !== 3'd2 || bus.gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL basic_second: gnt=%h idx=%0d vld=%b, need 04/2/1", bus.gnt, bus.gnt_idx, bus.gnt_vld);
    end
    // Non-owner request changes are ignored while a grant is held.
    bus.req = 8'hFC;
    tick();
    checks++;
    if (bus.gnt !== 8'h04 || bus.gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL basic_hold: gnt=%h vld=%b, need 04/1", bus.gnt, bus.gnt_vld);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (bus.gnt_vld !== 1'b0 || dbg_ptr !== 3'd3) begin
      failures++;
      $display("FAIL basic_release: vld=%b ptr=%0d, need 0/3", bus.gnt_vld, dbg_ptr);
    end
    // done while idle does nothing.
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt_vld !== 1'b0 || dbg_ptr !== 3'd3) begin
      failures++;
      $display("FAIL basic_idle_done: vld=%b ptr=%0d, need 0/3", bus.gnt_vld, dbg_ptr);
    end
  endtask

  task automatic test_wrap();
    bus.req = 8'h40;
    tick();
    bus.req = 8'h00;
    tick();
    checks++;
    if (dbg_ptr !== 3'd7) begin
      failures++;
      $display("FAIL wrap_ptr7: ptr=%0d, need 7", dbg_ptr);
    end
    bus.req = 8'h81;
    tick();
    checks++;
    if (bus.gnt !== 8'h80 || bus.gnt_idx !== 3'd7) begin
      failures++;
      $display("FAIL wrap_grant7: gnt=%h idx=%0d, need 80/7", bus.gnt, bus.gnt_idx);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0 || dbg_ptr !== 3'd0) begin
      failures++;
      $display("FAIL wrap_grant0: gnt=%h idx=%0d ptr=%0d, need 01/0/0", bus.gnt, bus.gnt_idx, dbg_ptr);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_drop();
    bus.req = 8'h18;
    tick();
    checks++;
    if (bus.gnt !== 8'h08 || bus.gnt_idx !== 3'd3) begin
      failures++;
      $display("FAIL drop_grant3: gnt=%h idx=%0d, need 08/3", bus.gnt, bus.gnt_idx);
    end
    bus.req = 8'h10;
    tick();
    checks++;
    if (bus.gnt_vld !== 1'b0 || bus.tmo !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: vld=%b tmo=%b, need 0/0", bus.gnt_vld, bus.tmo);
    end
    tick();
    checks++;
    if (bus.gnt !== 8'h10 || bus.gnt_idx !== 3'd4) begin
      failures++;
      $display("FAIL drop_grant4: gnt=%h idx=%0d, need 10/4", bus.gnt, bus.gnt_idx);
    end
    bus.req = 8'h00;
    tick();
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    bus.req = 8'h02;
    tick();
    for (int i = 0; i < 10 && bus.gnt_vld === 1'b1; i++) begin
      high_cycles++;
      tick();
    end
    checks++;
    if (high_cycles != 4) begin
      failures++;
      $display("FAIL tmo_width: grant cycles=%0d, need 4", high_cycles);
    end
    checks++;
    if (bus.tmo !== 1'b1 || bus.gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL tmo_pulse: tmo=%b vld=%b, need 1/0", bus.tmo, bus.gnt_vld);
    end
    tick();
    checks++;
    if (bus.tmo !== 1'b0 || bus.gnt !== 8'h02) begin
      failures++;
      $display("FAIL tmo_regrant: tmo=%b gnt=%h, need 0/02", bus.tmo, bus.gnt);
    end
    // Done on the same edge as cnt==HOLD_MAX is a normal release.
    tick();
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt_vld !== 1'b0 || bus.tmo !== 1'b0) begin
      failures++;
      $display("FAIL tmo_with_done: vld=%b tmo=%b, need 0/0", bus.gnt_vld, bus.tmo);
    end
    bus.req = 8'h00;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad_cycles;
    bad_cycles = 0;
    bus.req = 8'h02;
    tick();
    for (int i = 0; i < 22; i++) begin
      if (bus.gnt !== 8'h02 || bus.tmo !== 1'b0) bad_cycles++;
      tick();
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL no_tmo_hold: bad cycles=%0d, need 0 (gnt=%h tmo=%b)", bad_cycles, bus.gnt, bus.tmo);
    end
    checks++;
    if (dbg_cnt !== 8'd23) begin
      failures++;
      $display("FAIL no_tmo_cnt: cnt=%0d, need 23", dbg_cnt);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt_vld !== 1'b0 || bus.tmo !== 1'b0) begin
      failures++;
      $display("FAIL no_tmo_release: vld=%b tmo=%b, need 0/0", bus.gnt_vld, bus.tmo);
    end
    bus.req = 8'h00;
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant();
    bus.req = 8'h20;
    tick();
    checks++;
    if (bus.gnt !== 8'h20 || bus.gnt_idx !== 3'd5) begin
      failures++;
      $display("FAIL rstmid_grant5: gnt=%h idx=%0d, need 20/5", bus.gnt, bus.gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: gnt=%h vld=%b, need 00/0", bus.gnt, bus.gnt_vld);
    end
    bus.req = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_ptr0: gnt=%h idx=%0d, need 01/0", bus.gnt, bus.gnt_idx);
    end
    bus.req = 8'h00;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_drop();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
